// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, requester IDs and issue-FSM states for the DFT core arbiter
package fft_pkg;
  localparam int FFT_TDATA_W   = 64;
  localparam int FFT_TOUT_W    = 512;
  localparam int FFT_TAG_DEPTH = 8;
  localparam int FFT_CNT_W     = $clog2(FFT_TAG_DEPTH) + 1;
  typedef enum logic {REQ_FFT = 1'b0, REQ_IFFT = 1'b1} req_id_e;
  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_e;
endpackage

// File: rtl/fft_tag_fifo.sv
// fft_tag_fifo: 1-bit in-order tag FIFO with wrap-bit pointers and a registered occupancy count
module fft_tag_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_TAG_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wptr, r_rptr;
  logic [DEPTH-1:0] r_mem;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // full is judged before any same-cycle pop, so a pop never frees a slot for a push
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_mem   <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
      r_wptr  <= r_wptr + (AW+1)'(w_push);
      r_rptr  <= r_rptr + (AW+1)'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/fft_core_arbiter.sv
// fft_core_arbiter: round-robin sharing of one DFT core between two AXIS requesters, results steered by tag
module fft_core_arbiter
  import fft_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = FFT_TDATA_W,
  parameter int C_AXIS_TOUT_WIDTH  = FFT_TOUT_W,
  parameter int TAG_DEPTH          = FFT_TAG_DEPTH,
  parameter int CNT_WIDTH          = $clog2(TAG_DEPTH) + 1
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          s0_axis_tvalid,
  output logic                          s0_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                          s1_axis_tvalid,
  output logic                          s1_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
  output logic                          m_core_tvalid,
  input  logic                          m_core_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_core_tdata,
  input  logic                          c_core_tvalid,
  output logic                          c_core_tready,
  input  logic [C_AXIS_TOUT_WIDTH-1:0]  c_core_tdata,
  output logic                          r0_axis_tvalid,
  input  logic                          r0_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]  r0_axis_tdata,
  output logic                          r1_axis_tvalid,
  input  logic                          r1_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]  r1_axis_tdata,
  output logic [CNT_WIDTH-1:0]          outstanding,
  output logic                          err_orphan
);
  arb_state_e r_state, w_next;
  logic r_rr_ptr, r_grant, r_err;
  logic w_grant, w_sel_valid, w_hs, w_full, w_empty, w_head, w_pop, w_orphan;
  // grant is frozen in HOLD so the presented AXIS beat cannot change under backpressure
  assign w_grant     = (r_state == HOLD) ? r_grant
                     : (s0_axis_tvalid & s1_axis_tvalid) ? r_rr_ptr : s1_axis_tvalid;
  assign w_sel_valid = w_grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign m_core_tvalid  = s_axis_aresetn & w_sel_valid & ~w_full;
  assign m_core_tdata   = w_grant ? s1_axis_tdata : s0_axis_tdata;
  assign s0_axis_tready = s_axis_aresetn & (w_grant == REQ_FFT) & m_core_tready & ~w_full;
  assign s1_axis_tready = s_axis_aresetn & (w_grant == REQ_IFFT) & m_core_tready & ~w_full;
  assign w_hs           = m_core_tvalid & m_core_tready;
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) r_state <= ARB;
    else r_state <= w_next;
  always_comb begin
    w_next = w_hs ? ARB : m_core_tvalid ? HOLD : r_state;
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      r_rr_ptr <= 1'b0;
      r_grant  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) r_rr_ptr <= ~w_grant;
      if (r_state == ARB) r_grant <= w_grant;
      if (w_orphan) r_err <= 1'b1;
    end
  // results with no recorded tag are drained and dropped rather than stalling the core
  assign c_core_tready  = s_axis_aresetn & (w_empty | (w_head ? r1_axis_tready : r0_axis_tready));
  assign r0_axis_tvalid = c_core_tvalid & ~w_empty & ~w_head;
  assign r1_axis_tvalid = c_core_tvalid & ~w_empty & w_head;
  assign r0_axis_tdata  = c_core_tdata;
  assign r1_axis_tdata  = c_core_tdata;
  assign w_pop          = c_core_tvalid & c_core_tready & ~w_empty;
  assign w_orphan       = c_core_tvalid & c_core_tready & w_empty;
  assign err_orphan     = r_err;
  fft_tag_fifo #(.DEPTH(TAG_DEPTH), .CW(CNT_WIDTH)) u_tag_fifo (
    .clk     (s_axis_aclk),
    .rst_n   (s_axis_aresetn),
    .i_push  (w_hs),
    .i_din   (w_grant),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding)
  );
endmodule

// File: doc/fft_core_arbiter.md
Name: fft_core_arbiter

Overview:
- Shares one 8-point DFT core (64-bit frame in, 512-bit spectrum out, fixed 4-stage pipeline) between two AXI4-Stream requesters: channel 0 (forward FFT path) and channel 1 (IFFT path).
- Selects one 8-sample frame per handshake by round-robin and records the winner's ID in an in-order tag FIFO.
- Steers each core result back to the requester that issued it.
- Sits between the sample packers and the DFT core in the FFT/IFFT datapath.

Parameters:
- C_AXIS_TDATA_WIDTH, 64, frame width (8 x Q7 samples)
- C_AXIS_TOUT_WIDTH, 512, result width (8 x {real, imag} 32-bit)
- TAG_DEPTH, 8, tag FIFO entries (power of 2, >= 4); caps frames in flight
- CNT_WIDTH, 4, width of outstanding count ($clog2(TAG_DEPTH)+1)

Ports:
- s_axis_aclk  in  1  clock
- s_axis_aresetn  in  1  asynchronous reset, active-low
- s0_axis_tvalid / s0_axis_tready / s0_axis_tdata  in / out / in  1 / 1 / C_AXIS_TDATA_WIDTH  requester 0 frames
- s1_axis_tvalid / s1_axis_tready / s1_axis_tdata  in / out / in  1 / 1 / C_AXIS_TDATA_WIDTH  requester 1 frames
- m_core_tvalid / m_core_tready / m_core_tdata  out / in / out  1 / 1 / C_AXIS_TDATA_WIDTH  to DFT core input
- c_core_tvalid / c_core_tready / c_core_tdata  in / out / in  1 / 1 / C_AXIS_TOUT_WIDTH  from DFT core output
- r0_axis_tvalid / r0_axis_tready / r0_axis_tdata  out / in / out  1 / 1 / C_AXIS_TOUT_WIDTH  results to requester 0
- r1_axis_tvalid / r1_axis_tready / r1_axis_tdata  out / in / out  1 / 1 / C_AXIS_TOUT_WIDTH  results to requester 1
- outstanding  out  CNT_WIDTH  frames issued but not yet returned
- err_orphan  out  1  sticky: core result arrived with tag FIFO empty

Behaviour:
- Reset (async assert, sync release): rr_ptr=0 (s0 has priority), state=ARB, tag FIFO empty, outstanding=0, err_orphan=0. All tvalid/tready outputs are 0 while reset is asserted.
- Issue FSM, two states:
  - ARB: grant = the valid requester; if both are valid, grant = rr_ptr. Drive m_core_tvalid=1 and m_core_tdata from the grantee, only while tag FIFO not full.
    - On handshake (m_core_tvalid & m_core_tready): push grant ID, rr_ptr <= ~grant, stay in ARB.
    - If valid is shown but not accepted: latch grant, go to HOLD.
  - HOLD: grant frozen. The other requester is ignored even if it asserts valid. Stay until handshake, then push, update rr_ptr, return to ARB. This keeps AXIS data stable.
- sN_axis_tready = (grant==N) & m_core_tready & ~fifo_full. It is combinational with zero added latency, and the non-granted tready is always 0.
- Full: push only when count < TAG_DEPTH. A pop in the same cycle does not free the slot for a push (no pass-through). m_core_tvalid is deasserted when full.
- Return path: tag head selects the destination.
  - rH_axis_tvalid = c_core_tvalid & ~fifo_empty & (head==H). The other rN_axis_tvalid is 0.
  - rN_axis_tdata = c_core_tdata, pass-through to both outputs.
  - c_core_tready = fifo_empty ? 1 : rHEAD_axis_tready.
  - Pop on c_core_tvalid & c_core_tready & ~fifo_empty.
- Orphan: c_core_tvalid while fifo empty is drained (tready=1), the data is dropped, and err_orphan sets. It clears only on reset.
- Simultaneous push and pop: count unchanged, both pointers advance. outstanding = FIFO count, registered.
- Pointer wrap: log2(TAG_DEPTH)+1-bit read/write pointers. Full/empty is decided by MSB compare.
- Reset mid-operation: FIFO, FSM and the error flag clear immediately. In-flight core results after reset are orphans; the system resets the core together with this block.

Decomposition:
- Shared package fft_pkg: TAG_DEPTH default, requester ID encoding (REQ_FFT=0, REQ_IFFT=1), state encoding (ARB, HOLD), frame/result widths.
- One sub-module: fft_tag_fifo (1-bit wide sync FIFO with push/pop/full/empty/count). The arbiter FSM and the return demux stay in the top module.

Test Plan:
- Only s0 valid, frame 0x0000_0000_0000_0001, core ready → one handshake; after 4 cycles r0 receives the result; r1_axis_tvalid stays 0; outstanding goes 0→1→0.
- s0 and s1 both continuously valid after reset → issue order s0,s1,s0,s1; results return in the same alternating order on r0/r1.
- Both valid, core tready=0 for 3 cycles after s0 is shown; s1 toggles → grant holds s0, m_core_tdata stable, and s1 is issued next after release.
- r0_axis_tready held 0 with 8 frames issued → outstanding reaches 8, m_core_tvalid=0, both s tready=0; releasing r0 drains results in order and issue resumes.
- Inject c_core_tvalid=1 with no prior issue → c_core_tready=1, no rN valid, err_orphan=1 until reset.
- Assert s_axis_aresetn=0 with 3 frames in flight → outstanding=0, err_orphan=0, rr_ptr=0 at once; after release the first grant goes to s0 when both are valid.
